alu_result_checker: RTL



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_ref_model.sv | 29 ++
 rtl/alu_result_checker.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the logic-ALU checker and its golden reference model.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_NOTA = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit logic ALU: (op, a, b) -> expected result.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] expected_c,
    output logic             op_ok_c
);

    always_comb begin
        expected_c = '0;
        op_ok_c    = 1'b1;
        case (op_e'(op))
            OP_AND:  expected_c = a & b;
            OP_OR:   expected_c = a | b;
            OP_XOR:  expected_c = a ^ b;
            OP_XNOR: expected_c = ~(a ^ b);
            OP_NAND: expected_c = ~(a & b);
            OP_NOR:  expected_c = ~(a | b);
            OP_NOTA: expected_c = ~a;
            default: op_ok_c    = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage ALU response checker: register sample, compare against reference,
// count passes/fails, capture the first failure and publish a session report.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      end_req,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           op,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    input  logic [WIDTH-1:0]          y,
    output logic                      mismatch,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [CNT_W-1:0]          fail_cnt,
    output logic                      first_fail_valid,
    output logic [OP_W+3*WIDTH-1:0]   first_fail,
    output logic                      busy,
    output logic                      report_valid,
    output logic                      all_pass
);

    localparam int unsigned REC_W = OP_W + 3 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e state, state_next;

    logic             s1_valid;
    logic [OP_W-1:0]  s1_op;
    logic [WIDTH-1:0] s1_a, s1_b, s1_y;
    logic [WIDTH-1:0] exp_c;
    logic             op_ok_c;

    logic             clr_c, accept_c, retire_c, s1_fail_c;
    logic [CNT_W-1:0] pass_next, fail_next;
    logic             ff_valid_next;
    logic [REC_W-1:0] ff_next;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // start in RUN takes priority over end_req so a restart never drains
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_RUN;
            ST_RUN:    if (!start && end_req) state_next = ST_DRAIN;
            ST_DRAIN:  state_next = ST_REPORT;
            ST_REPORT: if (start) state_next = ST_RUN;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign clr_c    = start && (state != ST_DRAIN);
    assign accept_c = in_valid && in_ready && !start;
    assign retire_c = s1_valid && !clr_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
                s1_y  <= y;
            end
        end
    end

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .op         (s1_op),
        .a          (s1_a),
        .b          (s1_b),
        .expected_c (exp_c),
        .op_ok_c    (op_ok_c)
    );

    assign s1_fail_c = !op_ok_c || (exp_c != s1_y);

    // Saturating counters and first-fail capture
    always_comb begin
        pass_next     = pass_cnt;
        fail_next     = fail_cnt;
        ff_valid_next = first_fail_valid;
        ff_next       = first_fail;
        if (clr_c) begin
            pass_next     = '0;
            fail_next     = '0;
            ff_valid_next = 1'b0;
            ff_next       = '0;
        end else if (retire_c) begin
            if (s1_fail_c) begin
                if (fail_cnt != CNT_MAX) fail_next = fail_cnt + CNT_W'(1);
                if (!first_fail_valid) begin
                    ff_valid_next = 1'b1;
                    ff_next       = {s1_op, s1_a, s1_b, s1_y};
                end
            end else if (pass_cnt != CNT_MAX) begin
                pass_next = pass_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch         <= 1'b0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail       <= '0;
            in_ready         <= 1'b0;
            busy             <= 1'b0;
            report_valid     <= 1'b0;
            all_pass         <= 1'b0;
        end else begin
            mismatch         <= retire_c && s1_fail_c;
            pass_cnt         <= pass_next;
            fail_cnt         <= fail_next;
            first_fail_valid <= ff_valid_next;
            first_fail       <= ff_next;
            in_ready         <= (state_next == ST_RUN);
            busy             <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            report_valid     <= (state_next == ST_REPORT);
            all_pass         <= (state_next == ST_REPORT) && (fail_next == '0) && (pass_next != '0);
        end
    end

endmodule
